fsk_demodulador: RTL and testbench

FSK_DEMODULADOR -- requirements
Module: fsk_demodulador

---
 rtl/fsk_pkg.sv | 37 +++
 rtl/detector_cruzamento.sv | 45 ++++
 rtl/fsk_demodulador.sv | 105 ++++++++++
 tb/tb_fsk_demodulador.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fsk_pkg.sv
// Shared constants, lock-state enum and period classifier for the FSK demodulator.
// No logic state; pure declarations plus one combinational helper.
package fsk_pkg;

    localparam logic [7:0] MEIO_ESCALA = 8'd128;
    localparam logic [7:0] HISTERESE   = 8'd8;

    localparam logic [6:0] PER0_MIN = 7'd24;
    localparam logic [6:0] PER0_MAX = 7'd40;
    localparam logic [6:0] PER1_MIN = 7'd48;
    localparam logic [6:0] PER1_MAX = 7'd80;
    localparam logic [6:0] CONT_MAX = 7'd127;

    typedef enum logic [1:0] {
        BUSCA     = 2'd0,
        SINCRONIA = 2'd1,
        TRAVADO   = 2'd2
    } estado_t;

    typedef enum logic [1:0] {
        PER_INVALIDO = 2'd0,
        PER_BIT0     = 2'd1,
        PER_BIT1     = 2'd2
    } classe_t;

    function automatic classe_t classifica(input logic [6:0] periodo);
        classe_t c;
        c = PER_INVALIDO;
        if (periodo >= PER0_MIN && periodo <= PER0_MAX) begin
            c = PER_BIT0;
        end else if (periodo >= PER1_MIN && periodo <= PER1_MAX) begin
            c = PER_BIT1;
        end
        return c;
    endfunction

endpackage

// File: rtl/detector_cruzamento.sv
// Rising midscale-crossing detector; combinational strobe in the cycle of the accepted sample.
// No backpressure; optional hysteresis arm flag under FSK_DEMOD_HISTERESE_EN.
module detector_cruzamento
    import fsk_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_amostra,
    input  logic       i_amostra_valida,
    output logic       o_cruzamento
);

`ifdef FSK_DEMOD_HISTERESE_EN
    logic r_armado;

    // Arms only once the signal dips clearly below midscale, so noise around 128 cannot re-fire.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_armado <= 1'b0;
        end else if (i_amostra_valida) begin
            if (i_amostra < (MEIO_ESCALA - HISTERESE)) begin
                r_armado <= 1'b1;
            end else if (i_amostra >= MEIO_ESCALA) begin
                r_armado <= 1'b0;
            end
        end
    end

    assign o_cruzamento = i_amostra_valida && r_armado && (i_amostra >= MEIO_ESCALA);
`else
    logic [7:0] r_amostra_ant;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_amostra_ant <= MEIO_ESCALA;
        end else if (i_amostra_valida) begin
            r_amostra_ant <= i_amostra;
        end
    end

    assign o_cruzamento = i_amostra_valida && (r_amostra_ant < MEIO_ESCALA)
                          && (i_amostra >= MEIO_ESCALA);
`endif

endmodule

// File: rtl/fsk_demodulador.sv
// FSK demodulator: period measurement between rising crossings, bit decision and carrier lock FSM.
// Outputs appear one clock after the edge accepting a crossing sample; no backpressure, gaps just hold state.
module fsk_demodulador
    import fsk_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] amostra,
    input  logic       amostra_valida,
    output logic       dado,
    output logic       dado_valido,
    output logic       portadora,
    output logic       erro
);

    logic       w_cruzamento;
    classe_t    w_classe;

    logic [6:0] r_contador;
    estado_t    r_estado;
    logic       r_validos;
    logic       r_dec_vld;
    logic       r_dec_bit;
    logic       r_dec_err;

    detector_cruzamento u_detector (
        .i_clk            (clk),
        .i_rst_n          (reset),
        .i_amostra        (amostra),
        .i_amostra_valida (amostra_valida),
        .o_cruzamento     (w_cruzamento)
    );

    assign w_classe = classifica(r_contador);

    // Lock FSM and period counter; only valid samples advance anything here.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_estado   <= BUSCA;
            r_contador <= 7'd0;
            r_validos  <= 1'b0;
            r_dec_vld  <= 1'b0;
            r_dec_bit  <= 1'b0;
            r_dec_err  <= 1'b0;
        end else begin
            r_dec_vld <= 1'b0;
            r_dec_err <= 1'b0;
            if (amostra_valida) begin
                if (w_cruzamento) begin
                    r_contador <= 7'd1;
                    case (r_estado)
                        BUSCA: begin
                            r_estado  <= SINCRONIA;
                            r_validos <= 1'b0;
                        end
                        SINCRONIA, TRAVADO: begin
                            if (w_classe == PER_INVALIDO) begin
                                r_estado  <= BUSCA;
                                r_validos <= 1'b0;
                                r_dec_err <= 1'b1;
                            end else begin
                                r_dec_vld <= 1'b1;
                                r_dec_bit <= (w_classe == PER_BIT1);
                                if (r_estado == SINCRONIA) begin
                                    if (r_validos) begin
                                        r_estado <= TRAVADO;
                                    end
                                    r_validos <= 1'b1;
                                end
                            end
                        end
                        default: begin
                            r_estado  <= BUSCA;
                            r_validos <= 1'b0;
                        end
                    endcase
                end else if (r_contador != CONT_MAX) begin
                    r_contador <= r_contador + 7'd1;
                    // Reaching saturation means the carrier vanished: drop lock without flagging erro.
                    if (r_contador == (CONT_MAX - 7'd1)) begin
                        r_estado  <= BUSCA;
                        r_validos <= 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dado        <= 1'b0;
            dado_valido <= 1'b0;
            erro        <= 1'b0;
            portadora   <= 1'b0;
        end else begin
            dado_valido <= r_dec_vld;
            erro        <= r_dec_err;
            portadora   <= (r_estado == TRAVADO);
            if (r_dec_vld) begin
                dado <= r_dec_bit;
            end
        end
    end

endmodule

// File: tb/tb_fsk_demodulador.sv
// Scoreboard bench for fsk_demodulador: directed sine streams, expected decisions queued per crossing.
// A monitor pops one entry per dado_valido/erro pulse and checks bit, kind and pulse spacing.
module tb_fsk_demodulador;

    localparam real PI = 3.14159265358979;

    logic       clk;
    logic       reset;
    logic [7:0] amostra;
    logic       amostra_valida;
    logic       dado;
    logic       dado_valido;
    logic       portadora;
    logic       erro;

    typedef struct {
        logic e_erro;
        logic e_bit;
        int   e_gap;
    } esperado_t;

    esperado_t sb[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ultimo_vld = 0;

    fsk_demodulador dut (
        .clk            (clk),
        .reset          (reset),
        .amostra        (amostra),
        .amostra_valida (amostra_valida),
        .dado           (dado),
        .dado_valido    (dado_valido),
        .portadora      (portadora),
        .erro           (erro)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nome, input int got, input int want);
        checks = checks + 1;
        if (got != want) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", nome, got, want, cyc);
        end
    endtask

    function automatic logic [7:0] seno(input int n, input int k);
        real r;
        int  v;
        r = 100.0 * $sin(2.0 * PI * real'(k) / real'(n));
        v = 128 + ((r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5));
        return v[7:0];
    endfunction

    task automatic drive(input logic [7:0] v);
        @(negedge clk);
        amostra        = v;
        amostra_valida = 1'b1;
        @(posedge clk);
        #1;
        amostra_valida = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    task automatic faixa(input int n, input int k0, input int k1);
        for (int k = k0; k <= k1; k++) drive(seno(n, k));
    endtask

    task automatic periodo(input int n);
        faixa(n, 0, n - 1);
    endtask

    task automatic periodo_lento(input int n);
        for (int k = 0; k < n; k++) begin
            drive(seno(n, k));
            idle();
            idle();
        end
    endtask

    task automatic constante(input logic [7:0] v, input int cnt);
        for (int i = 0; i < cnt; i++) drive(v);
    endtask

    task automatic espera_bit(input logic b, input int gap);
        esperado_t e;
        e.e_erro = 1'b0;
        e.e_bit  = b;
        e.e_gap  = gap;
        sb.push_back(e);
    endtask

    task automatic espera_erro();
        esperado_t e;
        e.e_erro = 1'b1;
        e.e_bit  = 1'b0;
        e.e_gap  = 0;
        sb.push_back(e);
    endtask

    // Monitor: every output pulse must match the next queued expectation.
    initial begin
        esperado_t e;
        forever begin
            @(posedge clk);
            #1;
            if (dado_valido && erro) chk("vld_e_erro_juntos", 1, 0);
            if (dado_valido || erro) begin
                if (sb.size() == 0) begin
                    chk("pulso_inesperado", {30'd0, erro, dado_valido}, 0);
                end else begin
                    e = sb.pop_front();
                    chk("tipo_pulso_erro", int'(erro), int'(e.e_erro));
                    if (dado_valido && !e.e_erro) begin
                        chk("dado", int'(dado), int'(e.e_bit));
                        if (e.e_gap != 0) chk("intervalo_pulsos", cyc - ultimo_vld, e.e_gap);
                    end
                end
                if (dado_valido) ultimo_vld = cyc;
            end
        end
    end

    initial begin
        reset          = 1'b0;
        amostra        = 8'd128;
        amostra_valida = 1'b0;
        idle();
        idle();
        chk("rst_dado", int'(dado), 0);
        chk("rst_dado_valido", int'(dado_valido), 0);
        chk("rst_erro", int'(erro), 0);
        chk("rst_portadora", int'(portadora), 0);
        @(negedge clk);
        reset = 1'b1;

        // 32-sample sine: lock after the third crossing, bit 0 every 32 cycles.
        constante(8'd50, 4);
        periodo(32);
        chk("A_portadora_c1", int'(portadora), 0);
        espera_bit(1'b0, 0);
        periodo(32);
        chk("A_portadora_c2", int'(portadora), 0);
        espera_bit(1'b0, 32);
        periodo(32);
        chk("A_portadora_c3", int'(portadora), 1);
        espera_bit(1'b0, 32);
        periodo(32);

        // 64-sample sine gives bit 1, then back to 32 gives bit 0.
        espera_bit(1'b0, 32);
        periodo(64);
        espera_bit(1'b1, 64);
        periodo(64);
        chk("B_dado_64", int'(dado), 1);
        espera_bit(1'b1, 64);
        periodo(64);
        espera_bit(1'b1, 64);
        periodo(32);
        espera_bit(1'b0, 32);
        periodo(32);
        chk("B_dado_32", int'(dado), 0);
        chk("B_portadora", int'(portadora), 1);

        // Constant 200: one crossing, then saturation at the 127th sample drops lock silently.
        espera_bit(1'b0, 32);
        constante(8'd200, 126);
        idle();
        chk("C_portadora_126", int'(portadora), 1);
        constante(8'd200, 1);
        idle();
        chk("C_portadora_127", int'(portadora), 0);
        constante(8'd200, 3);
        chk("C_erro", int'(erro), 0);

        // Re-lock on bit 1, then a 16-sample period.
        constante(8'd50, 4);
        periodo(64);
        espera_bit(1'b1, 0);
        periodo(64);
        espera_bit(1'b1, 64);
        periodo(64);
        espera_bit(1'b1, 64);
        periodo(64);
        chk("D_portadora_trav", int'(portadora), 1);
        espera_bit(1'b1, 64);
        periodo(16);
        espera_erro();
        periodo(32);
        chk("D_dado_mantido", int'(dado), 1);
        chk("D_portadora_perdida", int'(portadora), 0);
        periodo(32);
        chk("D_portadora_busca", int'(portadora), 0);
        espera_bit(1'b0, 0);
        periodo(32);
        chk("D_portadora_sinc", int'(portadora), 0);

        // Valid only every third cycle: same decisions, spacing triples.
        espera_bit(1'b0, 0);
        periodo_lento(32);
        espera_bit(1'b0, 96);
        periodo_lento(32);
        espera_bit(1'b0, 96);
        periodo_lento(32);
        chk("E_portadora", int'(portadora), 1);
        chk("E_dado", int'(dado), 0);

        // Reset at sample 20 of a period while locked with dado = 1.
        espera_bit(1'b0, 0);
        periodo(64);
        espera_bit(1'b1, 0);
        faixa(64, 0, 19);
        chk("F_dado_pre", int'(dado), 1);
        chk("F_portadora_pre", int'(portadora), 1);
        reset = 1'b0;
        #1;
        chk("F_rst_dado", int'(dado), 0);
        chk("F_rst_portadora", int'(portadora), 0);
        chk("F_rst_dado_valido", int'(dado_valido), 0);
        chk("F_rst_erro", int'(erro), 0);
        idle();
        @(negedge clk);
        reset = 1'b1;
        faixa(64, 20, 63);
        periodo(64);
        chk("F_portadora_c1", int'(portadora), 0);
        espera_bit(1'b1, 0);
        periodo(64);
        chk("F_portadora_c2", int'(portadora), 0);
        espera_bit(1'b1, 64);
        periodo(64);
        chk("F_portadora_c3", int'(portadora), 1);

        for (int i = 0; i < 4; i++) idle();
        chk("fila_pendente", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
